// File: rtl/gpi_debounce_irq.sv
// gpi_debounce_irq: per-channel input conditioner for board switches/buttons.
// Each channel goes through a synchroniser, then a debounce counter (or a bypass
// path), and then edge detection. Edges set sticky write-1-to-clear status bits,
// and any set status bit raises a single registered interrupt line.
module gpi_debounce_irq #(
    parameter int unsigned Width          = 20,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 500000
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [Width-1:0] gp_raw_i,
    input  logic [Width-1:0] db_en_i,
    input  logic [Width-1:0] irq_rise_en_i,
    input  logic [Width-1:0] irq_fall_en_i,
    input  logic [Width-1:0] irq_clear_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic [Width-1:0] irq_status_o,
    output logic             irq_o
);

    localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    // Synchroniser chains; bit 0 is the first flop, bit SyncStages-1 is the stable output.
    logic [Width-1:0][SyncStages-1:0] r_sync;
    // Per-channel debounce counters.
    logic [Width-1:0][CntW-1:0]       r_cnt;
    // Accepted level, edge pulses, sticky status and interrupt.
    logic [Width-1:0]                 r_q;
    logic [Width-1:0]                 r_rise;
    logic [Width-1:0]                 r_fall;
    logic [Width-1:0]                 r_status;
    logic                             r_irq;

    logic [Width-1:0]                 w_s;
    logic [Width-1:0]                 w_q_next;
    logic [Width-1:0][CntW-1:0]       w_cnt_next;
    logic [Width-1:0]                 w_rise;
    logic [Width-1:0]                 w_fall;
    logic [Width-1:0]                 w_set;
    logic [Width-1:0]                 w_status_next;

    // Shift each raw pin through its synchroniser chain.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_sync <= '0;
        end else begin
            for (int unsigned ch = 0; ch < Width; ch++) begin
                r_sync[ch] <= {r_sync[ch][SyncStages-2:0], gp_raw_i[ch]};
            end
        end
    end

    // Pick out the last synchroniser stage of every channel.
    always_comb begin
        w_s = '0;
        for (int unsigned ch = 0; ch < Width; ch++) begin
            w_s[ch] = r_sync[ch][SyncStages-1];
        end
    end

    // Debounce decision: accept a change only after DebounceCycles consecutive
    // cycles of disagreement; bypassed channels follow the synchroniser directly.
    always_comb begin
        w_q_next   = r_q;
        w_cnt_next = r_cnt;
        for (int unsigned ch = 0; ch < Width; ch++) begin
            if (!db_en_i[ch]) begin
                w_q_next[ch]   = w_s[ch];
                w_cnt_next[ch] = '0;
            end else if (w_s[ch] == r_q[ch]) begin
                w_cnt_next[ch] = '0;
            end else if (r_cnt[ch] == CntMax) begin
                w_q_next[ch]   = w_s[ch];
                w_cnt_next[ch] = '0;
            end else begin
                w_cnt_next[ch] = r_cnt[ch] + 1'b1;
            end
        end
    end

    // Edge detection on the accepted level and status update from the current pulses.
    always_comb begin
        w_rise        = w_q_next & ~r_q;
        w_fall        = ~w_q_next & r_q;
        w_set         = (r_rise & irq_rise_en_i) | (r_fall & irq_fall_en_i);
        w_status_next = (r_status & ~irq_clear_i) | w_set;
    end

    // Register counters, level and edge pulses together so pulses align with the level change.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_q    <= w_q_next;
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    // Sticky status (set beats same-cycle clear) and interrupt one cycle behind status.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= w_status_next;
            r_irq    <= |r_status;
        end
    end

    assign gp_o         = r_q;
    assign rise_o       = r_rise;
    assign fall_o       = r_fall;
    assign irq_status_o = r_status;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_gpi_debounce_irq.sv
// Directed bench for gpi_debounce_irq: a per-cycle vector table with hand-computed
// outputs, plus hand-written sequences for reset mid-count and a DebounceCycles=1 instance.
module tb_gpi_debounce_irq;

    logic       clk;
    logic       rst;
    logic [3:0] raw, dben, clr;
    logic [3:0] gp, rise, fall, st;
    logic       irq;

    logic [3:0] raw1;
    logic [3:0] gp1, rise1, fall1, st1;
    logic       irq1;

    int total = 0;
    int bad   = 0;

    gpi_debounce_irq #(
        .Width(4),
        .SyncStages(2),
        .DebounceCycles(4)
    ) u_dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .gp_raw_i     (raw),
        .db_en_i      (dben),
        .irq_rise_en_i(4'b1111),
        .irq_fall_en_i(4'b1111),
        .irq_clear_i  (clr),
        .gp_o         (gp),
        .rise_o       (rise),
        .fall_o       (fall),
        .irq_status_o (st),
        .irq_o        (irq)
    );

    gpi_debounce_irq #(
        .Width(4),
        .SyncStages(2),
        .DebounceCycles(1)
    ) u_dut1 (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .gp_raw_i     (raw1),
        .db_en_i      (4'b1111),
        .irq_rise_en_i(4'b1111),
        .irq_fall_en_i(4'b1111),
        .irq_clear_i  (4'b0000),
        .gp_o         (gp1),
        .rise_o       (rise1),
        .fall_o       (fall1),
        .irq_status_o (st1),
        .irq_o        (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] dben;
        logic [3:0] clr;
        logic       rst;
        logic [3:0] gp;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] st;
        logic       irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] c,
                       input logic rs, input logic [3:0] egp, input logic [3:0] eri,
                       input logic [3:0] efa, input logic [3:0] est, input logic eirq);
        vec_t v;
        v.raw = r; v.dben = d; v.clr = c; v.rst = rs;
        v.gp = egp; v.rise = eri; v.fall = efa; v.st = est; v.irq = eirq;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; raw = '0; dben = 4'b1111; clr = '0; raw1 = '0;

        // Reset held 3 cycles, then idle.
        add(4'h0, 4'hF, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(4'h0, 4'hF, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(4'h0, 4'hF, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        // ch0 rises: level appears on the 6th edge, status one later, irq one after that.
        for (int i = 0; i < 5; i++) add(4'h1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(4'h1, 4'hF, 4'h0, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0);
        add(4'h1, 4'hF, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 0);
        add(4'h1, 4'hF, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        // ch1 high for only 3 cycles: rejected.
        for (int i = 0; i < 3; i++) add(4'h3, 4'hF, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        for (int i = 0; i < 3; i++) add(4'h1, 4'hF, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        // ch2 bypassed, 1-cycle pulse: level after 3 edges, rise then fall.
        add(4'h5, 4'hB, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        add(4'h1, 4'hB, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        add(4'h1, 4'hB, 4'h0, 0, 4'h5, 4'h4, 4'h0, 4'h1, 1);
        add(4'h1, 4'hB, 4'h0, 0, 4'h1, 4'h0, 4'h4, 4'h5, 1);
        add(4'h1, 4'hB, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h5, 1);
        // Clear ch2 status, then drop ch0.
        add(4'h1, 4'hF, 4'h4, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        for (int i = 0; i < 5; i++) add(4'h0, 4'hF, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h1, 4'h1, 1);
        // Clear during the fall pulse cycle: set wins.
        add(4'h0, 4'hF, 4'h1, 0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
        // Clear alone: status drops, irq follows one cycle later.
        add(4'h0, 4'hF, 4'h1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(4'h0, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);

        foreach (vecs[i]) begin
            raw = vecs[i].raw; dben = vecs[i].dben; clr = vecs[i].clr; rst = vecs[i].rst;
            step();
            chk($sformatf("v%0d gp", i),   {4'h0, gp},   {4'h0, vecs[i].gp});
            chk($sformatf("v%0d rise", i), {4'h0, rise}, {4'h0, vecs[i].rise});
            chk($sformatf("v%0d fall", i), {4'h0, fall}, {4'h0, vecs[i].fall});
            chk($sformatf("v%0d st", i),   {4'h0, st},   {4'h0, vecs[i].st});
            chk($sformatf("v%0d irq", i),  {7'h0, irq},  {7'h0, vecs[i].irq});
        end
        clr = '0; dben = 4'hF;

        // ch3 held high, reset after 2 counting cycles.
        raw = 4'h8;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("pre-rst%0d gp", k), {4'h0, gp}, 8'h00);
        end
        rst = 1'b1;
        step();
        chk("rst gp",   {4'h0, gp},   8'h00);
        chk("rst rise", {4'h0, rise}, 8'h00);
        chk("rst fall", {4'h0, fall}, 8'h00);
        chk("rst st",   {4'h0, st},   8'h00);
        chk("rst irq",  {7'h0, irq},  8'h00);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("post-rst%0d gp", k),   {4'h0, gp},   8'h00);
            chk($sformatf("post-rst%0d rise", k), {4'h0, rise}, 8'h00);
        end
        step();
        chk("post-rst6 gp",   {4'h0, gp},   8'h08);
        chk("post-rst6 rise", {4'h0, rise}, 8'h08);
        step();
        chk("post-rst7 rise", {4'h0, rise}, 8'h00);
        chk("post-rst7 st",   {4'h0, st},   8'h08);
        chk("post-rst7 irq",  {7'h0, irq},  8'h00);
        step();
        chk("post-rst8 irq",  {7'h0, irq},  8'h01);

        // DebounceCycles=1: change accepted after a single cycle of disagreement.
        raw1 = 4'h1;
        step();
        chk("d1 e1 gp", {4'h0, gp1}, 8'h00);
        step();
        chk("d1 e2 gp", {4'h0, gp1}, 8'h00);
        step();
        chk("d1 e3 gp",   {4'h0, gp1},   8'h01);
        chk("d1 e3 rise", {4'h0, rise1}, 8'h01);
        raw1 = 4'h0;
        step();
        chk("d1 e4 st", {4'h0, st1}, 8'h01);
        chk("d1 e4 gp", {4'h0, gp1}, 8'h01);
        step();
        chk("d1 e5 gp", {4'h0, gp1}, 8'h01);
        step();
        chk("d1 e6 gp",   {4'h0, gp1},   8'h00);
        chk("d1 e6 fall", {4'h0, fall1}, 8'h01);
        chk("d1 e6 irq",  {7'h0, irq1},  8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
